pulse_channel_mixer: RTL and testbench
======================================

// Module: pulse_channel_mixer
// PURPOSE
//  Parametrised N-channel pulse-wave generator with a time-multiplexed mixer.
//  Per channel: free-running phase accumulator, 4 duty modes, volume, enable.
//  On each sample strobe, snapshots all channel levels, sums them serially and
//  emits one scaled audio sample. Sits between the timing strobe generator and
//  the audio output pin.
// PARAMETERS
//  NUM_CH   3   number of pulse channels (>=1)
//  PHASE_W  32  phase accumulator / phase delta width (>=3)
//  VOL_W    4   per-channel volume width
//  OUT_W    8   output sample width (must be >= VOL_W)
// PORTS
//  i_clk           in   1                    system clock
//  i_rst_n         in   1                    async active-low reset
//  i_cfg_wr        in   1                    config write strobe
//  i_cfg_ch        in   max(1,clog2(NUM_CH)) target channel
//  i_cfg_sel       in   2                    0=phase delta 1=duty 2=volume 3=enable
//  i_cfg_data      in   PHASE_W              write data (LSBs used for duty/vol/en)
//  i_sample_stb    in   1                    request one mixed sample
//  o_audio_sample  out  OUT_W                last mixed sample, held between updates
//  o_sample_valid  out  1                    1-cycle pulse: o_audio_sample updated
//  o_busy          out  1                    mixer accumulating
//  o_overrun       out  1                    1-cycle pulse: strobe dropped while busy
// BEHAVIOUR
//  - Reset (async, on i_rst_n low): delta=0, duty=2, vol=0, en=0, phase=0 for all
//    channels; FSM IDLE; all outputs 0. Reset mid-ACCUM aborts; no valid pulse.
//  - Phase: enabled channel adds delta every clock, wrapping mod 2^PHASE_W;
//    disabled channel phase forced to 0 (cleared the cycle after en<=0).
//  - Pulse high when top 3 phase bits p < thr: duty 0/1/2/3 -> thr 1/2/4/6
//    (12.5/25/50/75%). Level = (en && high) ? vol : 0.
//  - Config: write registers on the clock edge where i_cfg_wr=1; i_cfg_ch>=NUM_CH
//    ignored. Delta write does not reset phase.
//  - FSM IDLE/ACCUM. IDLE + i_sample_stb in cycle T: snapshot all levels
//    (pre-write values if a cfg write coincides), acc<=0, idx<=0 -> ACCUM.
//  - ACCUM: o_busy=1 in cycles T+1..T+NUM_CH; one snapshot level added per cycle.
//    On the last add, o_audio_sample <= f(sum), o_sample_valid=1 in cycle
//    T+NUM_CH+1, FSM -> IDLE; a strobe in that cycle is accepted.
//  - Scaling: s = sum << (OUT_W-VOL_W), computed at full width
//    (VOL_W+clog2(NUM_CH)+OUT_W bits); f(sum) per CONFIGURATION.
//  - i_sample_stb while busy: ignored, o_overrun=1 next cycle; snapshot, acc,
//    output unaffected. Cfg writes during ACCUM never alter the snapshot.
// CONFIGURATION
//  PULSE_MIXER_SATURATE_EN defined: f = min(s, 2^OUT_W-1).
//  Not defined: f = s[OUT_W-1:0] (wrap); no saturation logic.
// TESTING
//  1 Reset asserted mid-run -> all outputs 0, phases 0; after release the first
//    strobe yields sample 0 (all vol=0).
//  2 ch0 delta=32'h2000_0000 duty=3 vol=15 en=1; 8 strobes 9 cycles apart ->
//    6 samples = 240, 2 samples = 0.
//  3 ch0..2 delta=0 duty=3 vol=15 en=1, strobe -> 255 with SATURATE_EN,
//    208 (720 mod 256) without.
//  4 Latency: strobe at T, NUM_CH=3 -> o_busy T+1..T+3, valid only at T+4;
//    strobe at T+4 accepted (busy T+5..T+7).
//  5 Strobe at T+2 -> o_overrun=1 at T+3; sample at T+4 unchanged vs no-overrun run.
//  6 Cfg write vol=15 to ch 3 (NUM_CH=3) -> no effect; write vol=8 to ch1 in same
//    cycle as strobe -> that sample uses old vol, next sample uses 8.

Source files
------------

// File: rtl/pulse_channel_mixer.sv
// N-channel pulse generator with serial mixer; sample valid NUM_CH+1 cycles after strobe.
// Strobes arriving while busy are dropped and flagged on o_overrun; PULSE_MIXER_SATURATE_EN clamps instead of wrapping.
module pulse_channel_mixer #(
  parameter int NUM_CH  = 3,
  parameter int PHASE_W = 32,
  parameter int VOL_W   = 4,
  parameter int OUT_W   = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_wr,
  input  logic [CH_W-1:0]    i_cfg_ch,
  input  logic [1:0]         i_cfg_sel,
  input  logic [PHASE_W-1:0] i_cfg_data,
  input  logic               i_sample_stb,
  output logic [OUT_W-1:0]   o_audio_sample,
  output logic               o_sample_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int SUM_W  = VOL_W + $clog2(NUM_CH);
  localparam int FULL_W = SUM_W + OUT_W;
  localparam int SHIFT  = OUT_W - VOL_W;

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state_q, state_d;

  logic [PHASE_W-1:0] delta_q [NUM_CH];
  logic [PHASE_W-1:0] phase_q [NUM_CH];
  logic [1:0]         duty_q  [NUM_CH];
  logic [VOL_W-1:0]   vol_q   [NUM_CH];
  logic [NUM_CH-1:0]  en_q;
  logic [VOL_W-1:0]   level   [NUM_CH];
  logic [VOL_W-1:0]   snap_q  [NUM_CH];
  logic [SUM_W-1:0]   acc_q, sum_next;
  logic [CH_W-1:0]    idx_q;
  logic               last_add;
  logic [OUT_W-1:0]   sample_f;

  function automatic logic [3:0] duty_thr(input logic [1:0] duty);
    case (duty)
      2'd0:    duty_thr = 4'd1;
      2'd1:    duty_thr = 4'd2;
      2'd2:    duty_thr = 4'd4;
      default: duty_thr = 4'd6;
    endcase
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      level[c] = '0;
      if (en_q[c] && ({1'b0, phase_q[c][PHASE_W-1 -: 3]} < duty_thr(duty_q[c])))
        level[c] = vol_q[c];
    end
  end

  // Phase advance uses the pre-write enable, so a fresh enable starts counting next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        delta_q[c] <= '0;
        phase_q[c] <= '0;
        duty_q[c]  <= 2'd2;
        vol_q[c]   <= '0;
      end
      en_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en_q[c]) phase_q[c] <= phase_q[c] + delta_q[c];
        else         phase_q[c] <= '0;
        if (i_cfg_wr && (i_cfg_ch == CH_W'(c))) begin
          case (i_cfg_sel)
            2'd0:    delta_q[c] <= i_cfg_data;
            2'd1:    duty_q[c]  <= i_cfg_data[1:0];
            2'd2:    vol_q[c]   <= i_cfg_data[VOL_W-1:0];
            default: en_q[c]    <= i_cfg_data[0];
          endcase
        end
      end
    end
  end

  assign last_add = (idx_q == CH_W'(NUM_CH - 1));
  assign sum_next = acc_q + SUM_W'(snap_q[idx_q]);

`ifdef PULSE_MIXER_SATURATE_EN
  logic [FULL_W-1:0] scaled;
  assign scaled   = FULL_W'(sum_next) << SHIFT;
  assign sample_f = (scaled > FULL_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
`else
  assign sample_f = OUT_W'({{OUT_W{1'b0}}, sum_next} << SHIFT);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_sample_stb) state_d = ACCUM;
      default: if (last_add)     state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) snap_q[c] <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      o_audio_sample <= '0;
      o_sample_valid <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      o_overrun      <= (state_q == ACCUM) && i_sample_stb;
      if (state_q == IDLE) begin
        if (i_sample_stb) begin
          snap_q <= level;
          acc_q  <= '0;
          idx_q  <= '0;
        end
      end else begin
        acc_q <= sum_next;
        idx_q <= idx_q + 1'b1;
        if (last_add) begin
          o_audio_sample <= sample_f;
          o_sample_valid <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (state_q == ACCUM);

endmodule

// File: tb/tb_pulse_channel_mixer.sv
// Directed bench for pulse_channel_mixer with a channel-level reference model and sample scoreboard.
module tb_pulse_channel_mixer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        sample_stb = 1'b0;
  logic [7:0]  audio_sample;
  logic        sample_valid, busy, overrun;

  int checks = 0;
  int failures = 0;
  int n240 = 0;
  logic [7:0] sb [$];

  logic [31:0] m_delta [3];
  logic [31:0] m_phase [3];
  logic [1:0]  m_duty  [3];
  logic [3:0]  m_vol   [3];
  logic        m_en    [3];

  pulse_channel_mixer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_wr(cfg_wr), .i_cfg_ch(cfg_ch),
    .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data), .i_sample_stb(sample_stb),
    .o_audio_sample(audio_sample), .o_sample_valid(sample_valid),
    .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_delta[c] <= '0; m_phase[c] <= '0; m_duty[c] <= 2'd2; m_vol[c] <= '0; m_en[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        m_phase[c] <= m_en[c] ? m_phase[c] + m_delta[c] : 32'd0;
        if (cfg_wr && cfg_ch == 2'(c)) begin
          case (cfg_sel)
            2'd0: m_delta[c] <= cfg_data;
            2'd1: m_duty[c]  <= cfg_data[1:0];
            2'd2: m_vol[c]   <= cfg_data[3:0];
            2'd3: m_en[c]    <= cfg_data[0];
          endcase
        end
      end
    end
  end

  function automatic logic [7:0] exp_now();
    int sum = 0;
    int thr, s, p;
    for (int c = 0; c < 3; c++) begin
      case (m_duty[c])
        2'd0: thr = 1; 2'd1: thr = 2; 2'd2: thr = 4; default: thr = 6;
      endcase
      p = int'(m_phase[c][31:29]);
      if (m_en[c] && p < thr) sum += int'(m_vol[c]);
    end
    s = sum * 16;
`ifdef PULSE_MIXER_SATURATE_EN
    if (s > 255) s = 255;
`else
    s = s % 256;
`endif
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else chk("sample", 32'(audio_sample), 32'(sb.pop_front()));
      if (audio_sample == 8'd240) n240++;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic strobe();
    sb.push_back(exp_now());
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic ch_setup(input logic [1:0] ch, input logic [31:0] dl, input logic [1:0] dy,
                          input logic [3:0] v, input logic e);
    cfg(ch, 2'd0, dl); cfg(ch, 2'd1, 32'(dy)); cfg(ch, 2'd2, 32'(v)); cfg(ch, 2'd3, 32'(e));
  endtask

  int base;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sample", 32'(audio_sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of accumulation aborts the sample.
    ch_setup(2'd0, 32'd0, 2'd3, 4'd15, 1'b1);
    strobe();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(sample_valid), 32'd0);
    chk("midrst_sample", 32'(audio_sample), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    strobe();
    repeat (3) tick();
    chk("post_rst_valid", 32'(sample_valid), 32'd1);
    chk("post_rst_sample", 32'(audio_sample), 32'd0);

    // One channel at 75% duty, strobes 9 cycles apart walk every phase octant.
    ch_setup(2'd0, 32'h2000_0000, 2'd3, 4'd15, 1'b1);
    base = n240;
    for (int i = 0; i < 8; i++) begin
      strobe();
      repeat (8) tick();
    end
    chk("duty75_count240", 32'(n240 - base), 32'd6);

    // All three channels full volume: clamp vs wrap.
    cfg(2'd0, 2'd3, 32'd0);
    cfg(2'd0, 2'd0, 32'd0);
    cfg(2'd0, 2'd3, 32'd1);
    ch_setup(2'd1, 32'd0, 2'd3, 4'd15, 1'b1);
    ch_setup(2'd2, 32'd0, 2'd3, 4'd15, 1'b1);
    strobe();
    repeat (3) tick();
`ifdef PULSE_MIXER_SATURATE_EN
    chk("full_mix", 32'(audio_sample), 32'd255);
`else
    chk("full_mix", 32'(audio_sample), 32'd208);
`endif
    tick();

    // Latency and back-to-back acceptance.
    sb.push_back(exp_now());
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    chk("lat_busy_t1", 32'(busy), 32'd1);
    chk("lat_valid_t1", 32'(sample_valid), 32'd0);
    tick();
    chk("lat_busy_t2", 32'(busy), 32'd1);
    tick();
    chk("lat_busy_t3", 32'(busy), 32'd1);
    chk("lat_valid_t3", 32'(sample_valid), 32'd0);
    tick();
    chk("lat_busy_t4", 32'(busy), 32'd0);
    chk("lat_valid_t4", 32'(sample_valid), 32'd1);
    strobe();
    chk("b2b_busy_t5", 32'(busy), 32'd1);
    chk("b2b_valid_t5", 32'(sample_valid), 32'd0);
    repeat (3) tick();
    chk("b2b_valid_t8", 32'(sample_valid), 32'd1);
    tick();

    // Overrun: strobe at T+2 is dropped and flagged at T+3.
    strobe();
    chk("ovr_t1", 32'(overrun), 32'd0);
    tick();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    chk("ovr_t3", 32'(overrun), 32'd1);
    tick();
    chk("ovr_t4", 32'(overrun), 32'd0);
    chk("ovr_sample", 32'(audio_sample), 32'(exp_now()));
    tick();
    chk("ovr_idle", 32'(busy), 32'd0);

    // Out-of-range channel ignored; write coinciding with strobe uses old volume.
    cfg(2'd0, 2'd2, 32'd1);
    cfg(2'd1, 2'd2, 32'd1);
    cfg(2'd2, 2'd2, 32'd1);
    cfg(2'd3, 2'd2, 32'd15);
    strobe();
    repeat (3) tick();
    chk("bad_ch_sample", 32'(audio_sample), 32'd48);
    sb.push_back(exp_now());
    sample_stb = 1'b1;
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_sel = 2'd2; cfg_data = 32'd8;
    tick();
    sample_stb = 1'b0; cfg_wr = 1'b0;
    repeat (3) tick();
    chk("coincide_old_vol", 32'(audio_sample), 32'd48);
    strobe();
    repeat (3) tick();
    chk("new_vol", 32'(audio_sample), 32'd160);

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
